// File: rtl/dct_coeff_collector.sv
// dct_coeff_collector
// Receive side of the 2-lane DCT coefficient stream. Each accepted pair is
// written into a staging register file at its natural-order index while a
// receive mask tracks which indices have arrived. When the mask fills, the
// staged frame is copied into a separate output register and announced with
// a one-cycle frame_valid. A duplicate index, or a gap in in_en mid-frame,
// aborts the partial frame with a one-cycle frame_err.
module dct_coeff_collector #(
  parameter int W    = 18,
  parameter int N    = 16,
  parameter int IDXW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic [W-1:0]      IN_A,
  input  logic [W-1:0]      IN_B,
  input  logic [IDXW-1:0]   IDX_A,
  input  logic [IDXW-1:0]   IDX_B,
  output logic [N*W-1:0]    coeffs_flat,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e             state_q;
  logic [N-1:0]       rx_mask_q;
  logic [W-1:0]       stage_q [N];
  logic [W-1:0]       stage_d [N];
  logic [N*W-1:0]     coeffs_flat_q;
  logic [N*W-1:0]     flat_d;
  logic               frame_valid_q;
  logic               frame_err_q;
  logic [15:0]        frame_cnt_q;
  logic               busy_q;

  logic [N-1:0]       sel_a;
  logic [N-1:0]       sel_b;
  logic [N-1:0]       new_bits;
  logic [N-1:0]       mask_merged;
  logic               pair_legal;
  logic               pair_write;
  logic               frame_done;
  logic               gap;

  // Decode the incoming pair against the receive mask.
  always_comb begin
    sel_a        = '0;
    sel_b        = '0;
    sel_a[IDX_A] = 1'b1;
    sel_b[IDX_B] = 1'b1;
    new_bits     = sel_a | sel_b;
    mask_merged  = rx_mask_q | new_bits;
    pair_legal   = (IDX_A != IDX_B) && ((rx_mask_q & new_bits) == '0);
    pair_write   = in_en && pair_legal;
    frame_done   = pair_write && (mask_merged == '1);
    gap          = !in_en && (state_q == COLLECT) && (rx_mask_q != '1);
  end

  // Staging contents including the pair being written this cycle, so the
  // completing pair lands in the published frame on the same edge.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (pair_write) begin
      stage_d[IDX_A] = IN_A;
      stage_d[IDX_B] = IN_B;
    end
  end

  // Flatten the next staging image into the output bus layout.
  always_comb begin
    flat_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      flat_d[k*W +: W] = stage_d[k];
    end
  end

  // IDLE/COLLECT FSM with staging, mask and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rx_mask_q     <= '0;
      coeffs_flat_q <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
      busy_q        <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        stage_q[k] <= stage_d[k];
      end
      if (in_en) begin
        if (!pair_legal) begin
          rx_mask_q   <= '0;
          frame_err_q <= 1'b1;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
        end else if (frame_done) begin
          coeffs_flat_q <= flat_d;
          frame_valid_q <= 1'b1;
          frame_cnt_q   <= frame_cnt_q + 16'd1;
          rx_mask_q     <= '0;
          state_q       <= IDLE;
          busy_q        <= 1'b0;
        end else begin
          rx_mask_q <= mask_merged;
          state_q   <= COLLECT;
          busy_q    <= 1'b1;
        end
      end else if (gap) begin
        rx_mask_q   <= '0;
        frame_err_q <= 1'b1;
        state_q     <= IDLE;
        busy_q      <= 1'b0;
      end
    end
  end

  assign coeffs_flat = coeffs_flat_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dct_coeff_collector.sv
// Directed self-checking bench for dct_coeff_collector.
module tb_dct_coeff_collector;

  localparam int W = 18;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_en;
  logic [W-1:0]   IN_A;
  logic [W-1:0]   IN_B;
  logic [3:0]     IDX_A;
  logic [3:0]     IDX_B;
  logic [N*W-1:0] coeffs_flat;
  logic           frame_valid;
  logic           frame_err;
  logic [15:0]    frame_cnt;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  int pa [8] = '{0, 4, 2, 10, 1, 5, 9, 13};
  int pb [8] = '{8, 12, 6, 14, 3, 7, 11, 15};

  logic [W-1:0]   fv [N];
  logic [N*W-1:0] exp_flat;
  logic [15:0]    exp_cnt;

  dct_coeff_collector #(.W(W), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_en       (in_en),
    .IN_A        (IN_A),
    .IN_B        (IN_B),
    .IDX_A       (IDX_A),
    .IDX_B       (IDX_B),
    .coeffs_flat (coeffs_flat),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_vals(input int base);
    for (int k = 0; k < N; k++) fv[k] = W'(k * 100 + base);
  endtask

  task automatic send_pair(input int ia, input int ib, input logic [W-1:0] va, input logic [W-1:0] vb);
    in_en = 1'b1;
    IDX_A = 4'(ia);
    IDX_B = 4'(ib);
    IN_A  = va;
    IN_B  = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Stream one full frame from fv in the fixed pair order, checking held
  // output mid-frame and the completion cycle.
  task automatic run_frame(input string tag);
    logic [N*W-1:0] new_flat;
    for (int k = 0; k < N; k++) new_flat[k*W +: W] = fv[k];
    for (int i = 0; i < 8; i++) begin
      send_pair(pa[i], pb[i], fv[pa[i]], fv[pb[i]]);
      if (i < 7) begin
        n_cmp++;
        if (frame_valid !== 1'b0) begin
          n_bad++; $display("FAIL %s mid_valid pair%0d: got %b want 0", tag, i, frame_valid);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++; $display("FAIL %s mid_busy pair%0d: got %b want 1", tag, i, busy);
        end
        n_cmp++;
        if (coeffs_flat !== exp_flat) begin
          n_bad++; $display("FAIL %s held_coeffs pair%0d: got %h want %h", tag, i, coeffs_flat, exp_flat);
        end
      end
    end
    exp_cnt  = exp_cnt + 16'd1;
    exp_flat = new_flat;
    n_cmp++;
    if (frame_valid !== 1'b1) begin
      n_bad++; $display("FAIL %s done_valid: got %b want 1", tag, frame_valid);
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL %s done_err: got %b want 0", tag, frame_err);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL %s done_busy: got %b want 0", tag, busy);
    end
    n_cmp++;
    if (coeffs_flat !== exp_flat) begin
      n_bad++; $display("FAIL %s done_coeffs: got %h want %h", tag, coeffs_flat, exp_flat);
    end
    n_cmp++;
    if (frame_cnt !== exp_cnt) begin
      n_bad++; $display("FAIL %s done_cnt: got %0d want %0d", tag, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_en = 1'b0; IN_A = '0; IN_B = '0; IDX_A = '0; IDX_B = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_flat = '0;
    exp_cnt  = '0;
    n_cmp++;
    if ({frame_valid, frame_err, busy} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {frame_valid, frame_err, busy});
    end
    n_cmp++;
    if (coeffs_flat !== '0) begin
      n_bad++; $display("FAIL reset_coeffs: got %h want 0", coeffs_flat);
    end
    n_cmp++;
    if (frame_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt);
    end
  endtask

  task automatic test_basic_frame();
    fill_vals(0);
    run_frame("basic");
    idle_cycle();
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_pulse_width: got %b want 0", frame_valid);
    end
    n_cmp++;
    if (coeffs_flat[3*W +: W] !== 18'd300) begin
      n_bad++; $display("FAIL basic_slot3: got %h want %h", coeffs_flat[3*W +: W], 18'd300);
    end
  endtask

  task automatic test_extremes();
    fill_vals(0);
    fv[5] = 18'h20000;
    fv[7] = 18'h1FFFF;
    run_frame("extremes");
    idle_cycle();
    n_cmp++;
    if (coeffs_flat[5*W +: W] !== 18'h20000) begin
      n_bad++; $display("FAIL extremes_slot5: got %h want 20000", coeffs_flat[5*W +: W]);
    end
    n_cmp++;
    if (coeffs_flat[7*W +: W] !== 18'h1FFFF) begin
      n_bad++; $display("FAIL extremes_slot7: got %h want 1ffff", coeffs_flat[7*W +: W]);
    end
  endtask

  task automatic test_gap();
    fill_vals(500);
    for (int i = 0; i < 4; i++) send_pair(pa[i], pb[i], fv[pa[i]], fv[pb[i]]);
    idle_cycle();
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_bad++; $display("FAIL gap_err: got %b want 1", frame_err);
    end
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_bad++; $display("FAIL gap_valid: got %b want 0", frame_valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL gap_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (coeffs_flat !== exp_flat) begin
      n_bad++; $display("FAIL gap_coeffs_held: got %h want %h", coeffs_flat, exp_flat);
    end
    idle_cycle();
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL gap_err_width: got %b want 0", frame_err);
    end
    fill_vals(700);
    run_frame("after_gap");
    idle_cycle();
  endtask

  task automatic test_duplicate();
    send_pair(0, 8, 18'd11, 18'd22);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL dup_busy_first: got %b want 1", busy);
    end
    send_pair(0, 4, 18'd33, 18'd44);
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_bad++; $display("FAIL dup_reuse_err: got %b want 1", frame_err);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL dup_reuse_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_bad++; $display("FAIL dup_reuse_valid: got %b want 0", frame_valid);
    end
    idle_cycle();
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL dup_idle_err: got %b want 0", frame_err);
    end
    send_pair(3, 3, 18'd55, 18'd66);
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_bad++; $display("FAIL dup_same_idx_err: got %b want 1", frame_err);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL dup_same_idx_busy: got %b want 0", busy);
    end
    idle_cycle();
    fill_vals(900);
    run_frame("after_dup");
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    fill_vals(1000);
    run_frame("b2b_f1");
    fill_vals(2000);
    run_frame("b2b_f2");
    idle_cycle();
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL b2b_err_after: got %b want 0", frame_err);
    end
  endtask

  task automatic test_reset_midframe();
    fill_vals(3000);
    for (int i = 0; i < 3; i++) send_pair(pa[i], pb[i], fv[pa[i]], fv[pb[i]]);
    in_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_flat = '0;
    exp_cnt  = '0;
    n_cmp++;
    if ({frame_valid, frame_err, busy} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid_flags: got %b want 000", {frame_valid, frame_err, busy});
    end
    n_cmp++;
    if (coeffs_flat !== '0) begin
      n_bad++; $display("FAIL rst_mid_coeffs: got %h want 0", coeffs_flat);
    end
    n_cmp++;
    if (frame_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rst_mid_cnt: got %0d want 0", frame_cnt);
    end
    idle_cycle();
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_no_err: got %b want 0", frame_err);
    end
    fill_vals(4000);
    run_frame("after_rst");
    n_cmp++;
    if (frame_cnt !== 16'd1) begin
      n_bad++; $display("FAIL rst_mid_cnt_one: got %0d want 1", frame_cnt);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_extremes();
    test_gap();
    test_duplicate();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
